hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core; works alongside the EX-stage operand forwarding logic.
- Decides every cycle which pipeline registers advance, which hold and which receive a bubble.
- Covers three conditions:
  - load-use hazards that forwarding cannot resolve;
  - variable-latency data-memory accesses, using a req/ack handshake with a timeout;
  - taken-branch flushes.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   hz_state_e      - controller state encoding (RUN / MEM_WAIT / ERROR)
//   REG_ZERO        - x0, never a real data dependence
//   TIMEOUT_CYC_DEF - default MEM-stage wait bound
//   CNT_W_DEF       - default wait counter width
//   src_hit()       - one source-operand dependence test
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         TIMEOUT_CYC_DEF = 64;
    localparam int         CNT_W_DEF       = 7;

    // True when an operand that is actually read matches the load destination.
    function automatic logic src_hit(input logic use_r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return use_r && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: event counters for the hazard controller.
//   clk, rst       - clock, synchronous active-high reset (clears counters)
//   stall_evt      - PC held this cycle (outside ERROR)
//   flush_evt      - branch flush applied this cycle
//   lu_evt         - load-use bubble inserted this cycle
//   stall_cyc_cnt, flush_cnt, load_use_cnt - 32-bit wrapping counts
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt,
    input  logic        flush_evt,
    input  logic        lu_evt,
    output logic [31:0] stall_cyc_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] load_use_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_cnt <= '0;
            flush_cnt     <= '0;
            load_use_cnt  <= '0;
        end else begin
            if (stall_evt) stall_cyc_cnt <= stall_cyc_cnt + 32'd1;
            if (flush_evt) flush_cnt     <= flush_cnt + 32'd1;
            if (lu_evt)    load_use_cnt  <= load_use_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Decides per cycle which pipeline registers advance, hold or take a bubble.
//   Inputs : clk, rst (sync, active high), rs1_id/rs2_id/use_rs*_id (ID
//            operands), rd_ex/mem_read_ex (EX load), mem_req_mem/mem_ack
//            (data memory handshake), branch_taken_ex.
//   Outputs: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
//            mem_wb_bubble, mem_err (sticky timeout error).
//   Optional: define HAZARD_PERF_CNT_EN to add stall_cyc_cnt, flush_cnt and
//            load_use_cnt outputs (32-bit event counters).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        use_rs1_id,
    input  logic        use_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic        mem_req_mem,
    input  logic        mem_ack,
    input  logic        branch_taken_ex,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_we,
    output logic        id_ex_flush,
    output logic        ex_mem_we,
    output logic        mem_wb_bubble,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cyc_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] load_use_cnt
`endif
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    hz_state_e        state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic load_use, mem_stall;

    assign load_use  = mem_read_ex && (rd_ex != REG_ZERO) &&
                       (src_hit(use_rs1_id, rs1_id, rd_ex) ||
                        src_hit(use_rs2_id, rs2_id, rd_ex));
    assign mem_stall = mem_req_mem && !mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b1;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;

        if (!rst) begin
            case (state)
                RUN, MEM_WAIT: begin
                    // Freeze when an access is outstanding: a new unacked
                    // request in RUN, or any cycle in MEM_WAIT without ack.
                    if ((state == RUN) ? mem_stall : !mem_ack) begin
                        pc_we         = 1'b0;
                        if_id_we      = 1'b0;
                        id_ex_we      = 1'b0;
                        ex_mem_we     = 1'b0;
                        mem_wb_bubble = 1'b1;
                        if (state == RUN) begin
                            state_nxt    = MEM_WAIT;
                            wait_cnt_nxt = CNT_W'(1);
                        end else if (wait_cnt == TO_VAL) begin
                            state_nxt = ERROR;
                        end else begin
                            wait_cnt_nxt = wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Released (or never frozen): the held ID/EX contents
                        // go through the normal branch / load-use rules.
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                        if (branch_taken_ex) begin
                            // Squashes the dependent instruction too, so a
                            // coincident load-use needs no extra bubble.
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use) begin
                            pc_we       = 1'b0;
                            if_id_we    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                ERROR: begin
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_we     = 1'b0;
                    mem_wb_bubble = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign mem_err = (state == ERROR);

`ifdef HAZARD_PERF_CNT_EN
    logic stall_evt, flush_evt, lu_evt;

    assign stall_evt = !pc_we && (state != ERROR);
    assign flush_evt = if_id_flush;
    assign lu_evt    = id_ex_flush && !if_id_flush;

    hazard_perf_cnt u_perf (
        .clk           (clk),
        .rst           (rst),
        .stall_evt     (stall_evt),
        .flush_evt     (flush_evt),
        .lu_evt        (lu_evt),
        .stall_cyc_cnt (stall_cyc_cnt),
        .flush_cnt     (flush_cnt),
        .load_use_cnt  (load_use_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed corner cases plus randomized stimulus checked
// against a cycle-level behavioural model of the controller.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, mem_read_ex;
    logic       mem_req_mem, mem_ack, branch_taken_ex;
    logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic       ex_mem_we, mem_wb_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cyc_cnt, flush_cnt, load_use_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .mem_req_mem     (mem_req_mem),
        .mem_ack         (mem_ack),
        .branch_taken_ex (branch_taken_ex),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_err         (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cyc_cnt   (stall_cyc_cnt),
        .flush_cnt       (flush_cnt),
        .load_use_cnt    (load_use_cnt)
`endif
    );

    // Output vector: {pc_we,if_id_we,if_id_flush,id_ex_we,id_ex_flush,
    //                 ex_mem_we,mem_wb_bubble,mem_err}
    localparam logic [7:0] V_NORM  = 8'b11010100;
    localparam logic [7:0] V_LU    = 8'b00011100;
    localparam logic [7:0] V_BR    = 8'b11111100;
    localparam logic [7:0] V_FRZ   = 8'b00000010;
    localparam logic [7:0] V_ERR   = 8'b00000011;
    localparam logic [7:0] V_RSTER = 8'b11010101;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: is an access outstanding, how many cycles it has waited,
    // has a timeout been recorded, and the expected event counts.
    bit  m_wait, m_err;
    int  m_waited;
    int  m_stall, m_flush, m_lu;
    logic [7:0] obs_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check outputs mid-cycle against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input bit r, input bit req, input bit ack, input bit br,
                         input bit mr, input logic [4:0] rde,
                         input logic [4:0] s1, input bit u1,
                         input logic [4:0] s2, input bit u2);
        bit lu, frozen;
        logic [7:0] e;
        rst = r; mem_req_mem = req; mem_ack = ack; branch_taken_ex = br;
        mem_read_ex = mr; rd_ex = rde; rs1_id = s1; use_rs1_id = u1;
        rs2_id = s2; use_rs2_id = u2;
        lu = mr && (rde != 0) && ((u1 && s1 == rde) || (u2 && s2 == rde));
        frozen = m_wait ? !ack : (req && !ack);
        if (r)          e = V_NORM | {7'b0, m_err};
        else if (m_err) e = V_ERR;
        else if (frozen) e = V_FRZ;
        else if (br)    e = V_BR;
        else if (lu)    e = V_LU;
        else            e = V_NORM;
        @(negedge clk);
        obs_v = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                 ex_mem_we, mem_wb_bubble, mem_err};
        chk("outs", obs_v, e);
        @(posedge clk);
        if (r) begin
            m_wait = 0; m_err = 0; m_waited = 0;
            m_stall = 0; m_flush = 0; m_lu = 0;
        end else begin
            if (!e[7] && !m_err) m_stall++;
            if (e[5]) m_flush++;
            if (e[3] && !e[5]) m_lu++;
            if (m_err) begin
            end else if (m_wait) begin
                if (ack)                m_wait = 0;
                else if (m_waited == TO) begin m_err = 1; m_wait = 0; end
                else                    m_waited++;
            end else if (req && !ack) begin
                m_wait = 1; m_waited = 1;
            end
        end
        #1;
    endtask

    task automatic idle();  cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic reset(); cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic mreq(input bit ack, input bit br);
        cycle(0, 1, ack, br, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mem_req_mem = 0; mem_ack = 0; branch_taken_ex = 0;
        mem_read_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        use_rs1_id = 0; use_rs2_id = 0;
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_lu = 0;
        @(posedge clk); #1;
        reset();                                   chk("rst_outs", obs_v, V_NORM);
        chk("rst_err", {31'b0, mem_err}, 0);

`ifdef HAZARD_PERF_CNT_EN
        // 1 load-use, 2 branches, 3-cycle memory wait
        cycle(0, 0, 0, 0, 1, 5'd5, 0, 0, 5'd5, 1);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        mreq(0, 0); mreq(0, 0); mreq(0, 0); mreq(1, 0);
        chk("perf_stall", stall_cyc_cnt, 4);
        chk("perf_flush", flush_cnt, 2);
        chk("perf_lu", load_use_cnt, 1);
        reset();
`endif

        // load-use through rs2, then normal
        cycle(0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1); chk("lu", obs_v, V_LU);
        idle();                                        chk("lu_after", obs_v, V_NORM);
        // rd_ex == x0 never stalls
        cycle(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1); chk("lu_x0", obs_v, V_NORM);
        // operand match but not read
        cycle(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 0); chk("lu_unused", obs_v, V_NORM);
        // branch with coincident load-use: flush only
        cycle(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0); chk("br_lu", obs_v, V_BR);

        // memory wait, ack on 4th cycle
        mreq(0, 0);                                    chk("mw1", obs_v, V_FRZ);
        mreq(0, 0);                                    chk("mw2", obs_v, V_FRZ);
        mreq(0, 0);                                    chk("mw3", obs_v, V_FRZ);
        mreq(1, 0);                                    chk("mw_rel", obs_v, V_NORM);
        // back-to-back access
        mreq(0, 0);                                    chk("b2b_frz", obs_v, V_FRZ);
        // branch held during wait is flushed on release
        mreq(1, 1);                                    chk("mw_rel_br", obs_v, V_BR);

        // timeout: 1 RUN stall + TO MEM_WAIT cycles, then ERROR ignoring ack
        for (int i = 0; i <= TO; i++) mreq(0, 0);
        chk("to_last_frz", obs_v, V_FRZ);
        mreq(1, 0);                                    chk("err", obs_v, V_ERR);
        idle();                                        chk("err_sticky", obs_v, V_ERR);
        reset();                                       chk("err_rst", obs_v, V_RSTER);
        idle();                                        chk("err_clr", obs_v, V_NORM);

        // ack in the timeout cycle wins
        for (int i = 0; i < TO; i++) mreq(0, 0);
        mreq(1, 0);                                    chk("to_ack", obs_v, V_NORM);
        idle();                                        chk("to_ack_run", obs_v, V_NORM);

        // reset mid-wait: no error, and a full fresh timeout window afterwards
        mreq(0, 0); mreq(0, 0);
        reset();
        idle();                                        chk("rst_mw", obs_v, V_NORM);
        for (int i = 0; i < TO; i++) mreq(0, 0);
        mreq(1, 0);                                    chk("rst_mw_cnt", obs_v, V_NORM);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("rnd_stall", stall_cyc_cnt, m_stall);
        chk("rnd_flush", flush_cnt, m_flush);
        chk("rnd_lu", load_use_cnt, m_lu);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
